// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader and its word packer.
package boot_pkg;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } boot_state_t;

endpackage

// File: rtl/boot_word_packer.sv
// Collects stream bytes MSB first into a 32-bit word and flags the 4th byte.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  // The word is presented combinationally so the byte that completes it is included.
  assign word      = {shreg, byte_in};
  assign word_full = byte_valid && (byte_cnt == 2'(WORD_BYTES - 1));

  // Shift in accepted bytes; a write or reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {shreg[15:0], byte_in};
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed, XOR-checksummed image into CPU memory and releases
// the CPU reset only when the checksum matches.
//
// state    | meaning
// S_LEN_HI | waiting for the high length byte
// S_LEN_LO | waiting for the low length byte, then range check
// S_DATA   | packing data bytes and accumulating the checksum
// S_WRITE  | one-cycle memory write of the packed word, input stalled
// S_CSUM   | waiting for the checksum byte
// S_DONE   | image accepted, CPU released (terminal)
// S_ERROR  | image rejected, CPU held (terminal)
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  boot_state_t      state;
  logic [7:0]       len_hi;
  logic [15:0]      n_words;
  logic [15:0]      len_next;
  logic [IDX_W-1:0] idx;
  logic [7:0]       csum;
  logic             accept;
  logic             pack_valid;
  logic [31:0]      word;
  logic             word_full;

  // Ready only in byte-consuming states; reset forces it low immediately.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_DATA)   || (state == S_CSUM);
    end
  end

  assign accept     = in_valid && in_ready;
  assign pack_valid = accept && (state == S_DATA);
  assign len_next   = {len_hi, in_data};

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == S_WRITE),
    .byte_valid (pack_valid),
    .byte_in    (in_data),
    .word       (word),
    .word_full  (word_full)
  );

  // Main sequencer with registered memory-port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LEN_HI;
      len_hi    <= 8'd0;
      n_words   <= 16'd0;
      idx       <= '0;
      csum      <= 8'd0;
      mem_write <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'd0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            n_words <= len_next;
            if ((len_next == 16'd0) || (len_next > 16'(MAX_WORDS))) begin
              error <= 1'b1;
              state <= S_ERROR;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ in_data;
            if (word_full) begin
              mem_write <= 1'b1;
              mem_addr  <= BASE_ADDR + (32'(idx) << 2);
              mem_wdata <= word;
              state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          idx <= idx + IDX_W'(1);
          if ((16'(idx) + 16'd1) == n_words) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
              state   <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
